// File: rtl/bt656_pkg.sv
// Shared constants and helpers for the BT.656 transmit path: timing-code bytes,
// blanking levels, slot classification and the XY protection-bit encoder.
package bt656_pkg;

  localparam logic [7:0] PRE_FF  = 8'hFF;
  localparam logic [7:0] PRE_00  = 8'h00;
  localparam logic [7:0] BLANK_C = 8'h80;
  localparam logic [7:0] BLANK_Y = 8'h10;

  typedef enum logic [1:0] {
    SLOT_EAV    = 2'd0,
    SLOT_BLANK  = 2'd1,
    SLOT_SAV    = 2'd2,
    SLOT_ACTIVE = 2'd3
  } slot_t;

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // 00 and FF are reserved for timing codes, so video data is pulled in by one step.
  function automatic logic [7:0] clamp8(input logic [7:0] d);
    if (d == 8'h00)      return 8'h01;
    else if (d == 8'hFF) return 8'hFE;
    else                 return d;
  endfunction

endpackage

// File: rtl/bt656_timing.sv
// Free-running byte-slot and line counters for the BT.656 raster, plus decode
// of the F/V bits, slot type, sync zones and the pixel-request window.
module bt656_timing
  import bt656_pkg::*;
#(
  parameter int H_TOTAL  = 1716,
  parameter int H_ACTIVE = 1440,
  parameter int V_TOTAL  = 525,
  parameter int F2_START = 266,
  parameter int V1_ACT   = 20,
  parameter int V1_END   = 263,
  parameter int V2_ACT   = 283,
  parameter int HS_WIDTH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  output slot_t      slot,
  output logic [1:0] code_idx,
  output logic       odd_slot,
  output logic       f_bit,
  output logic       v_bit,
  output logic       hs_zone,
  output logic       vs_zone,
  output logic       req_next,
  output logic       frame_end
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int LW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] EAV_END   = HW'(4);
  localparam logic [HW-1:0] SAV_START = HW'(H_TOTAL - H_ACTIVE - 4);
  localparam logic [HW-1:0] ACT_START = HW'(H_TOTAL - H_ACTIVE);
  localparam logic [HW-1:0] REQ_FIRST = HW'(H_TOTAL - H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_END    = HW'(HS_WIDTH);

  localparam logic [LW-1:0] L_FIRST  = LW'(1);
  localparam logic [LW-1:0] L_LAST   = LW'(V_TOTAL);
  localparam logic [LW-1:0] L_F1_END = LW'(3);
  localparam logic [LW-1:0] L_VS1_B  = LW'(4);
  localparam logic [LW-1:0] L_VS1_E  = LW'(6);
  localparam logic [LW-1:0] L_F2     = LW'(F2_START);
  localparam logic [LW-1:0] L_VS2_E  = LW'(F2_START + 2);
  localparam logic [LW-1:0] L_V1A    = LW'(V1_ACT);
  localparam logic [LW-1:0] L_V1E    = LW'(V1_END);
  localparam logic [LW-1:0] L_V2A    = LW'(V2_ACT);

  logic [HW-1:0] h_cnt;
  logic [LW-1:0] line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      line  <= L_FIRST;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      line  <= (line == L_LAST) ? L_FIRST : line + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    slot = SLOT_ACTIVE;
    if (h_cnt < EAV_END)        slot = SLOT_EAV;
    else if (h_cnt < SAV_START) slot = SLOT_BLANK;
    else if (h_cnt < ACT_START) slot = SLOT_SAV;
  end

  // SAV need not start on a multiple of 4, so its byte index is taken relative to its start.
  assign code_idx  = (slot == SLOT_SAV) ? (h_cnt[1:0] - SAV_START[1:0]) : h_cnt[1:0];
  assign odd_slot  = h_cnt[0];
  assign f_bit     = (line <= L_F1_END) || (line >= L_F2);
  assign v_bit     = !(((line >= L_V1A) && (line <= L_V1E)) || (line >= L_V2A));
  assign hs_zone   = (h_cnt < HS_END);
  assign vs_zone   = ((line >= L_VS1_B) && (line <= L_VS1_E)) ||
                     ((line >= L_F2) && (line <= L_VS2_E));
  // True one slot before every even active slot, so a registered request lands on it.
  assign req_next  = h_cnt[0] && (h_cnt >= REQ_FIRST) && (h_cnt != H_LAST);
  assign frame_end = (h_cnt == H_LAST) && (line == L_LAST);

endmodule

// File: rtl/bt656_encoder.sv
// BT.656 525-line transmitter: muxes EAV/SAV codes, blanking and clamped 4:2:2
// pixels into a registered byte stream, with HS/VS/field outputs aligned to it.
module bt656_encoder
  import bt656_pkg::*;
#(
  parameter int H_TOTAL  = 1716,
  parameter int H_ACTIVE = 1440,
  parameter int V_TOTAL  = 525,
  parameter int F2_START = 266,
  parameter int V1_ACT   = 20,
  parameter int V1_END   = 263,
  parameter int V2_ACT   = 283,
  parameter int HS_WIDTH = 128
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEnable,
  input  logic [15:0] iYCbCr,
  output logic        oReq,
  output logic        oCr_sel,
  output logic [7:0]  oTD_DATA,
  output logic        oTD_HS,
  output logic        oTD_VS,
  output logic        oField
);

  slot_t      slot;
  logic [1:0] code_idx;
  logic       odd_slot;
  logic       f_bit;
  logic       v_bit;
  logic       hs_zone;
  logic       vs_zone;
  logic       req_next;
  logic       frame_end;

  logic       en_q;
  logic       active_en;
  logic [7:0] y_q;
  logic [7:0] data_d;

  bt656_timing #(
    .H_TOTAL (H_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .F2_START(F2_START),
    .V1_ACT  (V1_ACT),
    .V1_END  (V1_END),
    .V2_ACT  (V2_ACT),
    .HS_WIDTH(HS_WIDTH)
  ) u_timing (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .slot     (slot),
    .code_idx (code_idx),
    .odd_slot (odd_slot),
    .f_bit    (f_bit),
    .v_bit    (v_bit),
    .hs_zone  (hs_zone),
    .vs_zone  (vs_zone),
    .req_next (req_next),
    .frame_end(frame_end)
  );

  assign active_en = en_q && !v_bit;

  always_comb begin
    data_d = odd_slot ? BLANK_Y : BLANK_C;
    case (slot)
      SLOT_EAV, SLOT_SAV: begin
        case (code_idx)
          2'd0:    data_d = PRE_FF;
          2'd3:    data_d = xy_code(f_bit, v_bit, slot == SLOT_EAV);
          default: data_d = PRE_00;
        endcase
      end
      SLOT_ACTIVE: begin
        if (active_en) data_d = odd_slot ? clamp8(y_q) : clamp8(iYCbCr[7:0]);
      end
      default: ;
    endcase
  end

  // Pixel handshake: oReq is high for exactly one clock per pixel; iYCbCr must be
  // valid (show-ahead) while oReq=1 and is consumed on the rising edge ending that
  // clock. oCr_sel tells the source which chroma sample the requested pixel carries.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oTD_DATA <= BLANK_C;
      oReq     <= 1'b0;
      oCr_sel  <= 1'b0;
      oTD_HS   <= 1'b1;
      oTD_VS   <= 1'b1;
      oField   <= 1'b1;
      en_q     <= 1'b0;
      y_q      <= 8'h00;
    end else begin
      oTD_DATA <= data_d;
      oReq     <= active_en && req_next;
      oTD_HS   <= !hs_zone;
      oTD_VS   <= !vs_zone;
      oField   <= f_bit;
      if (slot == SLOT_SAV) oCr_sel <= 1'b0;
      else if (oReq)        oCr_sel <= !oCr_sel;
      if (oReq) y_q <= iYCbCr[15:8];
      if (frame_end) en_q <= iEnable;
    end
  end

endmodule

// File: tb/tb_bt656_encoder.sv
// Directed bench: a full-size encoder for line-1..20 timing, and a shrunken
// raster (24 slots x 20 lines) for enable, pixel flow, field 2 and reset.
module tb_bt656_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_d, en_d, req_d, cr_d, hs_d, vs_d, fld_d;
  logic [15:0] yc_d;
  logic [7:0]  data_d;
  logic        rst_n_s, en_s, req_s, cr_s, hs_s, vs_s, fld_s;
  logic [15:0] yc_s;
  logic [7:0]  data_s;

  int total, bad, cyc, rel_d, rel_s;
  int req_cnt_d, req_cnt_s, pix_k;
  logic req_seen_s, mode_ramp, cap_on;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  logic cr_log[$];

  bt656_encoder dut_d (
    .iCLK(clk), .iRST_N(rst_n_d), .iEnable(en_d), .iYCbCr(yc_d),
    .oReq(req_d), .oCr_sel(cr_d), .oTD_DATA(data_d),
    .oTD_HS(hs_d), .oTD_VS(vs_d), .oField(fld_d)
  );

  bt656_encoder #(
    .H_TOTAL(24), .H_ACTIVE(10), .V_TOTAL(20), .F2_START(11),
    .V1_ACT(7), .V1_END(9), .V2_ACT(14), .HS_WIDTH(6)
  ) dut_s (
    .iCLK(clk), .iRST_N(rst_n_s), .iEnable(en_s), .iYCbCr(yc_s),
    .oReq(req_s), .oCr_sel(cr_s), .oTD_DATA(data_s),
    .oTD_HS(hs_s), .oTD_VS(vs_s), .oField(fld_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, then drive the small source show-ahead.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (req_seen_s) pix_k++;
    req_seen_s = req_s;
    yc_s = mode_ramp ? {pix_k[7:0], 8'h40 + pix_k[7:0]} : 16'hFF00;
    if (req_d) req_cnt_d++;
    if (req_s) begin
      req_cnt_s++;
      cr_log.push_back(cr_s);
    end
    if (cap_on) cap_q.push_back(data_s);
  endtask

  // Advance until the byte of absolute slot n (counted from reset release) is visible.
  task automatic goto_d(input int n);
    while (cyc < rel_d + n + 1) step();
  endtask

  task automatic goto_s(input int n);
    while (cyc < rel_s + n + 1) step();
  endtask

  task automatic chk_cap(input string tag);
    chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (cap_q.size() > 0 && exp_q.size() > 0)
      chk(tag, 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_cr_seq(input string tag);
    chk({tag, "_n"}, 32'(cr_log.size()), 32'd5);
    for (int i = 0; i < cr_log.size(); i++) chk(tag, 32'(cr_log[i]), 32'(i % 2));
    cr_log.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; rel_d = 0; rel_s = 0;
    req_cnt_d = 0; req_cnt_s = 0; pix_k = 0;
    req_seen_s = 1'b0; mode_ramp = 1'b0; cap_on = 1'b0;
    rst_n_d = 1'b0; rst_n_s = 1'b0; en_d = 1'b0; en_s = 1'b0;
    yc_d = 16'h1234; yc_s = 16'h0000;

    // Reset state
    repeat (3) step();
    chk("rst_data", 32'(data_d), 32'h80);
    chk("rst_req", 32'(req_d), 32'd0);
    chk("rst_cr", 32'(cr_d), 32'd0);
    chk("rst_hs", 32'(hs_d), 32'd1);
    chk("rst_vs", 32'(vs_d), 32'd1);
    chk("rst_fld", 32'(fld_d), 32'd1);
    chk("rst_data_s", 32'(data_s), 32'h80);

    // Full-size raster, video disabled
    rst_n_d = 1'b1; rel_d = cyc; req_cnt_d = 0;
    goto_d(0); chk("l1_eav0", 32'(data_d), 32'hFF); chk("l1_hs0", 32'(hs_d), 32'd0);
    goto_d(1); chk("l1_eav1", 32'(data_d), 32'h00);
    goto_d(2); chk("l1_eav2", 32'(data_d), 32'h00);
    goto_d(3); chk("l1_eav_xy", 32'(data_d), 32'hF1);
    goto_d(4); chk("l1_blk4", 32'(data_d), 32'h80);
    goto_d(5); chk("l1_blk5", 32'(data_d), 32'h10);
    goto_d(127); chk("hs_last_low", 32'(hs_d), 32'd0);
    goto_d(128); chk("hs_first_high", 32'(hs_d), 32'd1);
    goto_d(272); chk("l1_sav0", 32'(data_d), 32'hFF);
    goto_d(275); chk("l1_sav_xy", 32'(data_d), 32'hEC);
    goto_d(276); chk("l1_act0", 32'(data_d), 32'h80);
    goto_d(277); chk("l1_act1", 32'(data_d), 32'h10);
    goto_d(5147); chk("l3_vs", 32'(vs_d), 32'd1); chk("l3_fld", 32'(fld_d), 32'd1);
    goto_d(5148); chk("l4_vs", 32'(vs_d), 32'd0); chk("l4_fld", 32'(fld_d), 32'd0);
    goto_d(10295); chk("l6_vs", 32'(vs_d), 32'd0);
    goto_d(10296); chk("l7_vs", 32'(vs_d), 32'd1);
    en_d = 1'b1;
    goto_d(32607); chk("l20_eav_xy", 32'(data_d), 32'h9D);
    goto_d(32879); chk("l20_sav_xy", 32'(data_d), 32'h80);
    goto_d(32880); chk("l20_act_blank", 32'(data_d), 32'h80);
    chk("frame1_no_req", 32'(req_cnt_d), 32'd0);

    // Small raster: frame 1 disabled even though iEnable rises mid-frame
    rst_n_s = 1'b1; rel_s = cyc; req_cnt_s = 0; cr_log.delete();
    goto_s(3); chk("s_l1_eav_xy", 32'(data_s), 32'hF1);
    goto_s(100); en_s = 1'b1;
    goto_s(158); chk("s_f1_l7_blank", 32'(data_s), 32'h80);
    goto_s(479); chk("s_f1_no_req", 32'(req_cnt_s), 32'd0);

    // Frame 2 line 7: ramp Y=k, C=40+k
    goto_s(627); chk("s_l7_eav_xy", 32'(data_s), 32'h9D);
    goto_s(636); req_cnt_s = 0; cr_log.delete(); pix_k = 0; mode_ramp = 1'b1;
    goto_s(637); chk("s_l7_sav_xy", 32'(data_s), 32'h80); cap_on = 1'b1;
    goto_s(647); cap_on = 1'b0; mode_ramp = 1'b0;
    exp_q = {8'h40, 8'h01, 8'h41, 8'h01, 8'h42, 8'h02, 8'h43, 8'h03, 8'h44, 8'h04};
    chk_cap("ramp");
    chk("ramp_reqs", 32'(req_cnt_s), 32'd5);
    chk_cr_seq("ramp_cr");

    // Line 8: FF00 on every request; Cr select must be cleared by SAV
    goto_s(657); chk("cr_before_sav", 32'(cr_s), 32'd1);
    goto_s(660); req_cnt_s = 0; cr_log.delete();
    goto_s(661); cap_on = 1'b1;
    goto_s(671); cap_on = 1'b0;
    exp_q = {8'h01, 8'hFE, 8'h01, 8'hFE, 8'h01, 8'hFE, 8'h01, 8'hFE, 8'h01, 8'hFE};
    chk_cap("clamp");
    chk("clamp_reqs", 32'(req_cnt_s), 32'd5);
    chk_cr_seq("clamp_cr");

    // Line 10: first vertical-blanking line after field 1
    goto_s(695); req_cnt_s = 0;
    goto_s(699); chk("s_l10_eav_xy", 32'(data_s), 32'hB6);
    goto_s(710); chk("s_l10_act_blank", 32'(data_s), 32'h80);
    goto_s(719); chk("s_l10_no_req", 32'(req_cnt_s), 32'd0);
    chk("s_l10_fld", 32'(fld_s), 32'd0); chk("s_l10_vs", 32'(vs_s), 32'd1);
    goto_s(720); chk("s_l11_fld", 32'(fld_s), 32'd1); chk("s_l11_vs", 32'(vs_s), 32'd0);
    goto_s(791); chk("s_l13_vs", 32'(vs_s), 32'd0);
    goto_s(792); chk("s_l14_vs", 32'(vs_s), 32'd1);
    goto_s(795); chk("s_l14_eav_xy", 32'(data_s), 32'hDA);
    goto_s(804); req_cnt_s = 0;
    goto_s(805); chk("s_l14_sav_xy", 32'(data_s), 32'hC7);
    goto_s(815); chk("s_l14_reqs", 32'(req_cnt_s), 32'd5);

    // iEnable dropped mid-frame: rest of frame 2 stays active, frame 3 is blank
    goto_s(820); en_s = 1'b0;
    goto_s(852); req_cnt_s = 0;
    goto_s(863); chk("s_l16_reqs", 32'(req_cnt_s), 32'd5);
    goto_s(963); chk("s_f3_eav_xy", 32'(data_s), 32'hF1);
    goto_s(1104); req_cnt_s = 0;
    goto_s(1118); chk("s_f3_l7_blank", 32'(data_s), 32'h80);
    goto_s(1127); chk("s_f3_no_req", 32'(req_cnt_s), 32'd0);
    en_s = 1'b1;

    // Frame 4 line 8, mid-pixel: asynchronous reset
    goto_s(1623);
    chk("pre_rst_req", 32'(req_s), 32'd1);
    chk("pre_rst_cr", 32'(cr_s), 32'd1);
    chk("pre_rst_data", 32'(data_s), 32'hFE);
    rst_n_s = 1'b0;
    #1;
    chk("arst_data", 32'(data_s), 32'h80);
    chk("arst_req", 32'(req_s), 32'd0);
    chk("arst_cr", 32'(cr_s), 32'd0);
    chk("arst_fld", 32'(fld_s), 32'd1);
    chk("arst_hs", 32'(hs_s), 32'd1);
    chk("arst_vs", 32'(vs_s), 32'd1);
    repeat (3) step();
    chk("arst_hold", 32'(data_s), 32'h80);
    rst_n_s = 1'b1; rel_s = cyc;
    goto_s(0); chk("restart_eav0", 32'(data_s), 32'hFF); chk("restart_hs", 32'(hs_s), 32'd0);
    goto_s(3); chk("restart_xy", 32'(data_s), 32'hF1);
    goto_s(4); chk("restart_blk", 32'(data_s), 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
